// File: rtl/mips_register_file_pkg.sv
// Shared sizing constants for the MIPS register file and its scoreboard.
package mips_register_file_pkg;

   localparam int unsigned NUM_REGS = 8;
   localparam int unsigned ADDR_W   = 3;
   localparam int unsigned DATA_W   = 32;

   // Architectural zero register; reads as 0 and never becomes pending.
   localparam logic [ADDR_W-1:0] ZERO_REG = '0;

   // True when an index names a writable register.
   function automatic logic is_real_reg(input logic [ADDR_W-1:0] idx);
      return idx != ZERO_REG;
   endfunction

endpackage

// File: rtl/mips_register_file_reg_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue and cleared on
// writeback. It also flags read operands that still wait on a producer.
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   issue_valid, issue_reg instruction issuing with this destination
//   reg_write, write_reg   writeback retiring this destination
//   read_reg1, read_reg2   operand indices being read this cycle
//   pending                registered scoreboard vector
//   hazard                 combinational: an operand is still outstanding
module mips_register_file_reg_scoreboard
   import mips_register_file_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                issue_valid,
   input  logic [ADDR_W-1:0]   issue_reg,
   input  logic                reg_write,
   input  logic [ADDR_W-1:0]   write_reg,
   input  logic [ADDR_W-1:0]   read_reg1,
   input  logic [ADDR_W-1:0]   read_reg2,
   output logic [NUM_REGS-1:0] pending,
   output logic                hazard
);

   logic [NUM_REGS-1:0] pending_nxt;
   logic                h1;
   logic                h2;

   // Next scoreboard: clear on writeback first so a same-cycle issue wins.
   always_comb begin
      pending_nxt = pending;
      if (reg_write && is_real_reg(write_reg)) begin
         pending_nxt[write_reg] = 1'b0;
      end
      if (issue_valid && is_real_reg(issue_reg)) begin
         pending_nxt[issue_reg] = 1'b1;
      end
      pending_nxt[ZERO_REG] = 1'b0;
   end

   // Scoreboard register.
   always_ff @(posedge clk) begin
      if (reset) begin
         pending <= '0;
      end else begin
         pending <= pending_nxt;
      end
   end

   // A writeback landing this cycle is bypassed, so it resolves the hazard.
   always_comb begin
      h1     = pending[read_reg1] & ~(reg_write & (write_reg == read_reg1));
      h2     = pending[read_reg2] & ~(reg_write & (write_reg == read_reg2));
      hazard = h1 | h2;
   end

endmodule

// File: rtl/mips_register_file.sv
// 8 x 32-bit register file feeding the ALU operands. Two combinational read
// ports with write-first bypass, one synchronous writeback port, r0 fixed at 0,
// plus a pending-write scoreboard for issue stalls.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   read_reg1/2, read_data1/2  operand read ports (zero latency)
//   hazard                     an operand read has an outstanding write
//   reg_write, write_reg,
//   write_data                 writeback port
//   issue_valid, issue_reg     destination of the instruction issuing now
//   pending                    scoreboard vector
module mips_register_file
   import mips_register_file_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic [ADDR_W-1:0]   read_reg1,
   input  logic [ADDR_W-1:0]   read_reg2,
   output logic [DATA_W-1:0]   read_data1,
   output logic [DATA_W-1:0]   read_data2,
   output logic                hazard,
   input  logic                reg_write,
   input  logic [ADDR_W-1:0]   write_reg,
   input  logic [DATA_W-1:0]   write_data,
   input  logic                issue_valid,
   input  logic [ADDR_W-1:0]   issue_reg,
   output logic [NUM_REGS-1:0] pending
);

   logic [DATA_W-1:0] regs [NUM_REGS];

   // Register storage; writes to r0 are dropped so it stays 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (reg_write && is_real_reg(write_reg)) begin
         regs[write_reg] <= write_data;
      end
   end

   // Read port A: r0 forced to 0, then write-first bypass, then storage.
   always_comb begin
      if (!is_real_reg(read_reg1)) begin
         read_data1 = '0;
      end else if (reg_write && (write_reg == read_reg1)) begin
         read_data1 = write_data;
      end else begin
         read_data1 = regs[read_reg1];
      end
   end

   // Read port B: same rules as port A.
   always_comb begin
      if (!is_real_reg(read_reg2)) begin
         read_data2 = '0;
      end else if (reg_write && (write_reg == read_reg2)) begin
         read_data2 = write_data;
      end else begin
         read_data2 = regs[read_reg2];
      end
   end

   mips_register_file_reg_scoreboard u_scoreboard (
      .clk         (clk),
      .reset       (reset),
      .issue_valid (issue_valid),
      .issue_reg   (issue_reg),
      .reg_write   (reg_write),
      .write_reg   (write_reg),
      .read_reg1   (read_reg1),
      .read_reg2   (read_reg2),
      .pending     (pending),
      .hazard      (hazard)
   );

endmodule

// File: tb/tb_mips_register_file.sv
// Bench for mips_register_file: a directed table of hand-computed vectors
// followed by random traffic compared against an array-based reference model.
module tb_mips_register_file;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  read_reg1, read_reg2;
   logic [31:0] read_data1, read_data2;
   logic        hazard;
   logic        reg_write;
   logic [2:0]  write_reg;
   logic [31:0] write_data;
   logic        issue_valid;
   logic [2:0]  issue_reg;
   logic [7:0]  pending;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mips_register_file dut (
      .clk         (clk),
      .reset       (reset),
      .read_reg1   (read_reg1),
      .read_reg2   (read_reg2),
      .read_data1  (read_data1),
      .read_data2  (read_data2),
      .hazard      (hazard),
      .reg_write   (reg_write),
      .write_reg   (write_reg),
      .write_data  (write_data),
      .issue_valid (issue_valid),
      .issue_reg   (issue_reg),
      .pending     (pending)
   );

   typedef struct {
      logic        rst;
      logic        rw;
      logic [2:0]  wr;
      logic [31:0] wd;
      logic        iv;
      logic [2:0]  ir;
      logic [2:0]  r1;
      logic [2:0]  r2;
      logic        chk;
      logic [31:0] e1;
      logic [31:0] e2;
      logic        eh;
      logic [7:0]  ep;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rst, rw, input logic [2:0] wr, input logic [31:0] wd,
                      input logic iv, input logic [2:0] ir, r1, r2, input logic chk,
                      input logic [31:0] e1, e2, input logic eh, input logic [7:0] ep);
      vec_t v;
      v.rst = rst; v.rw = rw; v.wr = wr; v.wd = wd; v.iv = iv; v.ir = ir;
      v.r1 = r1; v.r2 = r2; v.chk = chk; v.e1 = e1; v.e2 = e2; v.eh = eh; v.ep = ep;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic drive(input logic rst, rw, input logic [2:0] wr, input logic [31:0] wd,
                        input logic iv, input logic [2:0] ir, r1, r2);
      reset = rst; reg_write = rw; write_reg = wr; write_data = wd;
      issue_valid = iv; issue_reg = ir; read_reg1 = r1; read_reg2 = r2;
   endtask

   // Reference model state
   logic [31:0] mregs [8];
   logic [7:0]  mpend;

   function automatic logic [31:0] mread(input logic [2:0] idx);
      if (idx == 3'd0) return 32'h0;
      if (reg_write && write_reg == idx) return write_data;
      return mregs[idx];
   endfunction

   function automatic logic mhaz(input logic [2:0] idx);
      return mpend[idx] && !(reg_write && write_reg == idx);
   endfunction

   task automatic model_edge();
      if (reset) begin
         foreach (mregs[i]) mregs[i] = 32'h0;
         mpend = 8'h00;
      end else begin
         if (reg_write && write_reg != 3'd0) begin
            mregs[write_reg] = write_data;
            mpend[write_reg] = 1'b0;
         end
         if (issue_valid && issue_reg != 3'd0) mpend[issue_reg] = 1'b1;
      end
   endtask

   initial begin
      drive(1'b1, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 3'd0, 3'd0);

      //  rst rw wr  wd            iv ir  r1  r2  chk e1            e2            eh  ep
      add(1, 0, 0, 32'h0,        0, 0,  0,  0,  0,  32'h0,        32'h0,        0,  8'h00);
      add(0, 0, 0, 32'h0,        0, 0,  0,  1,  1,  32'h0,        32'h0,        0,  8'h00);
      add(0, 0, 0, 32'h0,        0, 0,  2,  3,  1,  32'h0,        32'h0,        0,  8'h00);
      add(0, 0, 0, 32'h0,        0, 0,  4,  5,  1,  32'h0,        32'h0,        0,  8'h00);
      add(0, 0, 0, 32'h0,        0, 0,  6,  7,  1,  32'h0,        32'h0,        0,  8'h00);
      add(0, 1, 1, 32'h33,       0, 0,  2,  0,  1,  32'h0,        32'h0,        0,  8'h00);
      add(0, 1, 2, 32'h29,       0, 0,  1,  0,  1,  32'h33,       32'h0,        0,  8'h00);
      add(0, 0, 0, 32'h0,        0, 0,  1,  2,  1,  32'h33,       32'h29,       0,  8'h00);
      add(0, 1, 0, 32'hAAAAAAAA, 1, 0,  0,  0,  1,  32'h0,        32'h0,        0,  8'h00);
      add(0, 0, 0, 32'h0,        0, 0,  0,  1,  1,  32'h0,        32'h33,       0,  8'h00);
      add(0, 1, 3, 32'h33333333, 0, 0,  3,  2,  1,  32'h33333333, 32'h29,       0,  8'h00);
      add(0, 0, 0, 32'h0,        1, 5,  5,  3,  1,  32'h0,        32'h33333333, 0,  8'h00);
      add(0, 0, 0, 32'h0,        0, 0,  5,  0,  1,  32'h0,        32'h0,        1,  8'h20);
      add(0, 1, 5, 32'h55,       0, 0,  0,  5,  1,  32'h0,        32'h55,       0,  8'h20);
      add(0, 0, 0, 32'h0,        0, 0,  5,  0,  1,  32'h55,       32'h0,        0,  8'h00);
      add(0, 1, 4, 32'h44,       1, 4,  4,  0,  1,  32'h44,       32'h0,        0,  8'h00);
      add(0, 0, 0, 32'h0,        0, 0,  4,  0,  1,  32'h44,       32'h0,        1,  8'h10);
      add(0, 0, 0, 32'h0,        1, 1,  0,  0,  1,  32'h0,        32'h0,        0,  8'h10);
      add(0, 0, 0, 32'h0,        1, 2,  0,  0,  1,  32'h0,        32'h0,        0,  8'h12);
      add(0, 0, 0, 32'h0,        1, 3,  0,  0,  1,  32'h0,        32'h0,        0,  8'h16);
      add(0, 0, 0, 32'h0,        1, 5,  0,  0,  1,  32'h0,        32'h0,        0,  8'h1E);
      add(0, 0, 0, 32'h0,        1, 6,  0,  0,  1,  32'h0,        32'h0,        0,  8'h3E);
      add(0, 0, 0, 32'h0,        1, 7,  0,  0,  1,  32'h0,        32'h0,        0,  8'h7E);
      // Reset with a full scoreboard and an in-flight write that must be lost
      add(1, 1, 1, 32'h0000FFFF, 1, 2,  1,  7,  1,  32'h0000FFFF, 32'h0,        1,  8'hFE);
      add(0, 0, 0, 32'h0,        0, 0,  1,  2,  1,  32'h0,        32'h0,        0,  8'h00);
      add(0, 0, 0, 32'h0,        0, 0,  3,  5,  1,  32'h0,        32'h0,        0,  8'h00);
      add(0, 0, 0, 32'h0,        0, 0,  4,  7,  1,  32'h0,        32'h0,        0,  8'h00);

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].rw, vecs[i].wr, vecs[i].wd,
               vecs[i].iv, vecs[i].ir, vecs[i].r1, vecs[i].r2);
         #2;
         if (vecs[i].chk) begin
            check($sformatf("vec%0d read_data1", i), read_data1, vecs[i].e1);
            check($sformatf("vec%0d read_data2", i), read_data2, vecs[i].e2);
            check($sformatf("vec%0d hazard", i), 32'(hazard), 32'(vecs[i].eh));
            check($sformatf("vec%0d pending", i), 32'(pending), 32'(vecs[i].ep));
         end
         @(posedge clk);
         #1;
      end

      // Table ends in a clean post-reset state; model starts from there.
      foreach (mregs[i]) mregs[i] = 32'h0;
      mpend = 8'h00;

      for (int n = 0; n < 400; n++) begin
         drive(($urandom_range(0, 49) == 0), 1'($urandom), 3'($urandom), $urandom,
               1'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
         #2;
         check("rand read_data1", read_data1, mread(read_reg1));
         check("rand read_data2", read_data2, mread(read_reg2));
         check("rand hazard", 32'(hazard), 32'(mhaz(read_reg1) || mhaz(read_reg2)));
         check("rand pending", 32'(pending), 32'(mpend));
         @(posedge clk);
         model_edge();
         #1;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
